// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// sources: one start strobe per grant, with a completion watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*DATA_W-1:0]  i_req_data,
    output logic [N_REQ-1:0]         o_grant,
    input  logic                     i_tx_busy,
    input  logic                     i_tx_done,
    output logic                     o_tx_start,
    output logic [DATA_W-1:0]        o_tx_data,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [CW-1:0]       r_cnt;
    logic                w_found;
    logic                w_load;
    logic                w_tmo;
    logic                w_adv;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_sel;
    logic [PW-1:0]       w_ptr_inc;
    logic [N_REQ-1:0]    w_onehot;
    logic [DATA_W-1:0]   w_bytes [N_REQ];

    assign w_tmo     = (r_cnt == CNT_LAST);
    assign w_onehot  = N_REQ'(1) << w_sel;
    assign w_ptr_inc = (o_owner == PW'(N_REQ - 1)) ? '0 : o_owner + PW'(1);

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_bytes[i] = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan downward so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = PW'((int'(r_ptr) + i) % N_REQ);
            if (i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_adv) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_adv      = 1'b0;
        unique case (r_state)
            S_IDLE: w_load = w_found && !i_tx_busy;
            S_WAIT: begin
                w_done_nxt = i_tx_done;
                w_err_nxt  = !i_tx_done && w_tmo;
                w_adv      = i_tx_done || w_tmo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_owner    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else begin
            o_grant    <= w_load ? w_onehot : '0;
            o_tx_start <= w_load;
            o_busy     <= (w_state_nxt != S_IDLE);
            o_done     <= w_done_nxt;
            o_err      <= w_err_nxt;
            if (w_load) begin
                o_tx_data <= w_bytes[w_sel];
                o_owner   <= w_sel;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_adv) begin
                r_ptr <= w_ptr_inc;
            end
        end
    end

endmodule
